// File: rtl/pixel_fb_if.sv
// Sprite pixel stream in, framebuffer write port out, plus clear control/status.
// The writer takes the slave side; whoever drives pixels and models memory takes the master side.
interface pixel_fb_if #(
   parameter int unsigned ADDR_W = 17
);
   logic              plot_in;
   logic [9:0]        x_in;
   logic [9:0]        y_in;
   logic [2:0]        color_in;
   logic              clear_req;
   logic [2:0]        clear_color;
   logic              fb_ready;
   logic              fb_we;
   logic [ADDR_W-1:0] fb_addr;
   logic [2:0]        fb_data;
   logic              busy;
   logic              clear_done;
   logic              overflow;

   modport master (
      output plot_in, x_in, y_in, color_in, clear_req, clear_color, fb_ready,
      input  fb_we, fb_addr, fb_data, busy, clear_done, overflow
   );

   modport slave (
      input  plot_in, x_in, y_in, color_in, clear_req, clear_color, fb_ready,
      output fb_we, fb_addr, fb_data, busy, clear_done, overflow
   );
endinterface

// File: rtl/pixel_fb_writer.sv
// Clips/colour-keys sprite pixels, linearises them into a fall-through FIFO and drains
// them to a single-port framebuffer; a clear engine fills the screen between frames.
module pixel_fb_writer #(
   parameter int unsigned SCREEN_W   = 320,
   parameter int unsigned SCREEN_H   = 240,
   parameter int unsigned ADDR_W     = 17,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter bit          KEY_EN     = 1'b1,
   parameter logic [2:0]  KEY_COLOR  = 3'b000
) (
   input  logic       clk,
   input  logic       reset_n,
   pixel_fb_if.slave  bus
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);

   typedef enum logic {IDLE, CLEAR} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] clr_cnt_q;
   logic [2:0]        clr_col_q;
   logic              done_q;
   logic              ovf_q;

   logic              stg_vld_q;
   logic [ADDR_W-1:0] stg_addr_q;
   logic [2:0]        stg_col_q;

   logic [ADDR_W-1:0] fa_q [FIFO_DEPTH];
   logic [2:0]        fc_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wp_q, rp_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              pix_ok, empty, full, flush, pop, push, wr;
   logic [ADDR_W-1:0] pix_addr;

   assign pix_ok = bus.plot_in
                && (32'(bus.x_in) < SCREEN_W)
                && (32'(bus.y_in) < SCREEN_H)
                && !(KEY_EN && (bus.color_in == KEY_COLOR));
   assign pix_addr = ADDR_W'(bus.y_in) * ADDR_W'(SCREEN_W) + ADDR_W'(bus.x_in);

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == FULL_CNT);
   // A clear request discards everything already queued, including the stage entry.
   assign flush = (state_q == IDLE) && bus.clear_req;
   assign pop   = (state_q == IDLE) && !empty && bus.fb_ready;
   assign push  = stg_vld_q && !flush;
   assign wr    = push && (!full || pop);

   always_comb begin
      cnt_d = cnt_q;
      unique case ({wr, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stg_vld_q  <= 1'b0;
         stg_addr_q <= '0;
         stg_col_q  <= '0;
      end else begin
         stg_vld_q <= pix_ok;
         if (pix_ok) begin
            stg_addr_q <= pix_addr;
            stg_col_q  <= bus.color_in;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (flush) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (wr)  wp_q <= wp_q + PTR_W'(1);
         if (pop) rp_q <= rp_q + PTR_W'(1);
         cnt_q <= cnt_d;
         if (push && !wr) ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr) begin
         fa_q[wp_q] <= stg_addr_q;
         fc_q[wp_q] <= stg_col_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         clr_cnt_q <= '0;
         clr_col_q <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: if (bus.clear_req) begin
               state_q   <= CLEAR;
               clr_col_q <= bus.clear_color;
               clr_cnt_q <= '0;
            end
            CLEAR: if (bus.fb_ready) begin
               if (clr_cnt_q == LAST_ADDR) begin
                  state_q   <= IDLE;
                  done_q    <= 1'b1;
                  clr_cnt_q <= '0;
               end else begin
                  clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Head is gated so the bus reads all-zero whenever nothing is being written.
   assign bus.busy       = (state_q == CLEAR);
   assign bus.fb_we      = bus.busy || !empty;
   assign bus.fb_addr    = bus.busy ? clr_cnt_q : (empty ? '0 : fa_q[rp_q]);
   assign bus.fb_data    = bus.busy ? clr_col_q : (empty ? '0 : fc_q[rp_q]);
   assign bus.clear_done = done_q;
   assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Randomised and directed stimulus against a queue-based model of the framebuffer write stream.
module tb_pixel_fb_writer;
   localparam int W     = 320;
   localparam int H     = 240;
   localparam int DEPTH = 8;
   localparam int NPIX  = W * H;

   typedef struct {int addr; int data;} wr_t;

   logic clk, reset_n;
   pixel_fb_if #(.ADDR_W(17)) bus();

   pixel_fb_writer #(
      .SCREEN_W(W), .SCREEN_H(H), .ADDR_W(17), .FIFO_DEPTH(DEPTH),
      .KEY_EN(1'b1), .KEY_COLOR(3'b000)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   wr_t exp_q[$];
   int  errors = 0, checks = 0;
   int  n_wr = 0, busy_cyc = 0, done_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit visible(input int x, input int y, input int c);
      return (x < W) && (y < H) && (c != 0);
   endfunction

   task automatic plot(input int x, input int y, input int c, input bit expect_wr);
      bus.plot_in  = 1'b1;
      bus.x_in     = 10'(x);
      bus.y_in     = 10'(y);
      bus.color_in = 3'(c);
      if (expect_wr && visible(x, y, c)) exp_q.push_back('{y * W + x, c});
   endtask

   task automatic idle();
      bus.plot_in = 1'b0;
   endtask

   task automatic push_clear(input int c);
      for (int a = 0; a < NPIX; a++) exp_q.push_back('{a, c});
   endtask

   task automatic wait_empty(input string name, input int lim);
      for (int k = 0; k < lim && exp_q.size() != 0; k++) tick();
      chk(name, exp_q.size(), 0);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_we"},    int'(bus.fb_we), 0);
      chk({tag, "_addr"},  int'(bus.fb_addr), 0);
      chk({tag, "_data"},  int'(bus.fb_data), 0);
      chk({tag, "_busy"},  int'(bus.busy), 0);
      chk({tag, "_done"},  int'(bus.clear_done), 0);
      chk({tag, "_ovf"},   int'(bus.overflow), 0);
   endtask

   // Monitor: every accepted write is matched against the head of the expected queue.
   initial begin
      logic        prev_stall, prev_busy;
      logic [16:0] prev_addr;
      logic [2:0]  prev_data;
      wr_t         e;
      prev_stall = 1'b0;
      prev_busy  = 1'b0;
      prev_addr  = '0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prev_stall = 1'b0;
            continue;
         end
         if (prev_stall && bus.fb_we && (bus.busy == prev_busy)) begin
            chk("stall_addr_stable", int'(bus.fb_addr), int'(prev_addr));
            chk("stall_data_stable", int'(bus.fb_data), int'(prev_data));
         end
         if (bus.fb_we && bus.fb_ready) begin
            n_wr++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: addr %0d data %0d with nothing pending",
                        bus.fb_addr, bus.fb_data);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", int'(bus.fb_addr), e.addr);
               chk("wr_data", int'(bus.fb_data), e.data);
            end
         end
         if (bus.busy)       busy_cyc++;
         if (bus.clear_done) done_cnt++;
         prev_stall = bus.fb_we && !bus.fb_ready;
         prev_busy  = bus.busy;
         prev_addr  = bus.fb_addr;
         prev_data  = bus.fb_data;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n0, b0, d0;
      bit found;
      reset_n         = 1'b0;
      bus.plot_in     = 1'b0;
      bus.x_in        = '0;
      bus.y_in        = '0;
      bus.color_in    = '0;
      bus.clear_req   = 1'b0;
      bus.clear_color = '0;
      bus.fb_ready    = 1'b0;
      #12;
      chk_outputs_zero("reset");
      #10;
      reset_n = 1'b1;
      tick();

      // single pixel latency: plot in cycle N, write visible in N+2
      bus.fb_ready = 1'b1;
      plot(5, 2, 3, 1'b1);
      tick();
      idle();
      @(negedge clk);
      chk("lat_n1_we", int'(bus.fb_we), 0);
      @(negedge clk);
      chk("lat_n2_we",   int'(bus.fb_we), 1);
      chk("lat_n2_addr", int'(bus.fb_addr), 645);
      chk("lat_n2_data", int'(bus.fb_data), 3);
      tick();
      wait_empty("single_drain", 20);

      // clipped and keyed pixels vanish
      n0 = n_wr;
      plot(320, 0, 2, 1'b1); tick();
      plot(0, 240, 2, 1'b1); tick();
      plot(10, 10, 0, 1'b1); tick();
      idle();
      repeat (5) tick();
      chk("clip_writes", n_wr - n0, 0);
      chk("clip_ovf", int'(bus.overflow), 0);

      // random stream with random backpressure, throttled so nothing overflows
      for (int i = 0; i < 500; i++) begin
         bus.fb_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 1) == 1 && exp_q.size() < DEPTH)
            plot($urandom_range(0, 335), $urandom_range(0, 255), $urandom_range(0, 7), 1'b1);
         else
            idle();
         tick();
      end
      idle();
      bus.fb_ready = 1'b1;
      wait_empty("random_drain", 50);
      chk("random_ovf", int'(bus.overflow), 0);

      // backpressure: 12 plots into an 8-deep FIFO, only the first 8 survive
      n0 = n_wr;
      bus.fb_ready = 1'b0;
      for (int i = 0; i < 12; i++) begin
         plot(20 + i, 3, (i % 7) + 1, i < DEPTH);
         tick();
      end
      idle();
      repeat (5) tick();
      chk("bp_ovf", int'(bus.overflow), 1);
      bus.fb_ready = 1'b1;
      wait_empty("bp_drain", 40);
      repeat (3) tick();
      chk("bp_writes", n_wr - n0, DEPTH);

      // full clear with stale pixels pending, a same-cycle plot and plots during clear
      bus.fb_ready = 1'b0;
      plot(50, 5, 4, 1'b1); tick();
      plot(51, 5, 4, 1'b1); tick();
      plot(52, 5, 4, 1'b1); tick();
      idle();
      repeat (3) tick();
      bus.clear_req   = 1'b1;
      bus.clear_color = 3'b001;
      exp_q.delete();
      push_clear(1);
      plot(1, 1, 5, 1'b1);
      b0 = busy_cyc;
      d0 = done_cnt;
      tick();
      bus.clear_req = 1'b0;
      bus.fb_ready  = 1'b1;
      plot(7, 0, 2, 1'b1); tick();
      plot(8, 0, 6, 1'b1); tick();
      idle();
      for (int k = 0; k < 80000 && done_cnt == d0; k++) @(negedge clk);
      tick();
      wait_empty("clear_drain", 50);
      chk("clear_busy_cycles", busy_cyc - b0, NPIX);
      chk("clear_done_pulses", done_cnt - d0, 1);
      chk("clear_busy_after", int'(bus.busy), 0);

      // reset in the middle of a clear
      bus.clear_req   = 1'b1;
      bus.clear_color = 3'b100;
      exp_q.delete();
      push_clear(4);
      tick();
      bus.clear_req = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 3000 && !found; k++) begin
         @(negedge clk);
         if (bus.busy && bus.fb_addr == 17'd1000) found = 1'b1;
      end
      chk("midclear_reached_1000", int'(found), 1);
      #1;
      reset_n = 1'b0;
      exp_q.delete();
      #1;
      chk_outputs_zero("midclear_reset");
      d0 = done_cnt;
      #20;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (20) tick();
      chk("post_reset_busy", int'(bus.busy), 0);
      chk("post_reset_we", int'(bus.fb_we), 0);
      chk("post_reset_no_done", done_cnt - d0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
